// File: rtl/pong_pkg.sv
// Scan-code constants, command codes and held-vector bit positions shared by
// the pong keyboard front end.
package pong_pkg;

    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_J     = 8'h3B;
    localparam logic [7:0] SC_L     = 8'h4B;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_KEY1  = 8'h16;
    localparam logic [7:0] SC_KEY2  = 8'h1E;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    localparam logic [1:0] CMD_SPACE = 2'd0;
    localparam logic [1:0] CMD_ESC   = 2'd1;
    localparam logic [1:0] CMD_KEY1  = 2'd2;
    localparam logic [1:0] CMD_KEY2  = 2'd3;

    // Held-vector layout {KEY2,KEY1,ESC,SPACE,L,J,D,A}; bit 2 set marks a control key
    // and bits [1:0] of a control key's index equal its command code.
    localparam logic [2:0] HELD_A     = 3'd0;
    localparam logic [2:0] HELD_D     = 3'd1;
    localparam logic [2:0] HELD_J     = 3'd2;
    localparam logic [2:0] HELD_L     = 3'd3;
    localparam logic [2:0] HELD_SPACE = {1'b1, CMD_SPACE};
    localparam logic [2:0] HELD_ESC   = {1'b1, CMD_ESC};
    localparam logic [2:0] HELD_KEY1  = {1'b1, CMD_KEY1};
    localparam logic [2:0] HELD_KEY2  = {1'b1, CMD_KEY2};

    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_BRK,
        DEC_EXT,
        DEC_EXT_BRK
    } dec_state_t;

    // Returns {is_game_key, held_index}.
    function automatic logic [3:0] key_lookup(input logic [7:0] code);
        case (code)
            SC_A:     return {1'b1, HELD_A};
            SC_D:     return {1'b1, HELD_D};
            SC_J:     return {1'b1, HELD_J};
            SC_L:     return {1'b1, HELD_L};
            SC_SPACE: return {1'b1, HELD_SPACE};
            SC_ESC:   return {1'b1, HELD_ESC};
            SC_KEY1:  return {1'b1, HELD_KEY1};
            SC_KEY2:  return {1'b1, HELD_KEY2};
            default:  return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/pong_input_scheduler_if.sv
// Control-command valid/ready channel from the input scheduler to the game FSM.
interface pong_input_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_code;

    modport master (output cmd_valid, output cmd_code, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/pong_cmd_fifo.sv
// DEPTH x 2-bit synchronous FIFO; a push while full is accepted only when a pop
// happens at the same edge.
module pong_cmd_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [1:0] din,
    output logic [1:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/pong_input_scheduler.sv
// PS/2 scan-code decoder, held-key tracker, control-command queue and
// frame-divided paddle movement scheduler for the pong game FSM.
module pong_input_scheduler
    import pong_pkg::*;
#(
    parameter int unsigned MOVE_DIV  = 3,
    parameter int unsigned CMD_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          done,
    input  logic [7:0]                    tasta,
    input  logic                          frame_tick,
    input  logic                          move_en,
    pong_input_scheduler_if.master        cmd,
    output logic                          cmd_overflow,
    output logic                          mv_p1_left,
    output logic                          mv_p1_right,
    output logic                          mv_p2_left,
    output logic                          mv_p2_right,
    output logic [7:0]                    keys_held
);

    localparam int unsigned CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    dec_state_t    state;
    logic          old_done;
    logic          byte_evt;
    logic [3:0]    lookup;
    logic          key_hit;
    logic [2:0]    key_idx;
    logic          make_evt;
    logic          break_evt;
    logic          new_press;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [3:0]    tap;
    logic [3:0]    tap_set;
    logic [3:0]    want;
    logic [3:0]    strobe;
    logic          fire;
    logic [CW-1:0] frame_cnt;

    assign byte_evt  = done && !old_done;
    assign lookup    = key_lookup(tasta);
    assign key_hit   = lookup[3];
    assign key_idx   = lookup[2:0];
    assign make_evt  = byte_evt && (state == DEC_IDLE) && key_hit;
    assign break_evt = byte_evt && (state == DEC_BRK) && key_hit;
    assign new_press = make_evt && !keys_held[key_idx];
    assign push      = new_press && key_idx[2];
    assign tap_set   = (new_press && !key_idx[2]) ? (4'b0001 << key_idx[1:0]) : 4'b0000;

    assign cmd.cmd_valid = !fifo_empty;
    assign pop           = !fifo_empty && cmd.cmd_ready;

    pong_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (key_idx[1:0]),
        .dout  (cmd.cmd_code),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= DEC_IDLE;
            old_done     <= 1'b0;
            keys_held    <= '0;
            cmd_overflow <= 1'b0;
        end else begin
            old_done <= done;
            if (push && fifo_full && !pop) begin
                cmd_overflow <= 1'b1;
            end
            if (new_press) begin
                keys_held[key_idx] <= 1'b1;
            end
            if (break_evt) begin
                keys_held[key_idx] <= 1'b0;
            end
            if (byte_evt) begin
                case (state)
                    DEC_IDLE: begin
                        if (tasta == SC_BREAK) begin
                            state <= DEC_BRK;
                        end else if (tasta == SC_EXT) begin
                            state <= DEC_EXT;
                        end
                    end
                    DEC_EXT:     state <= (tasta == SC_BREAK) ? DEC_EXT_BRK : DEC_IDLE;
                    DEC_BRK:     state <= DEC_IDLE;
                    DEC_EXT_BRK: state <= DEC_IDLE;
                    default:     state <= DEC_IDLE;
                endcase
            end
        end
    end

    // Opposite directions of one player cancel; clearing every active bit on a
    // scheduled tick consumes single taps and drops both taps of a conflict.
    assign want   = keys_held[3:0] | tap;
    assign fire   = move_en && frame_tick && (frame_cnt == CW'(MOVE_DIV - 1));
    assign strobe = {want[3] & ~want[2], want[2] & ~want[3],
                     want[1] & ~want[0], want[0] & ~want[1]};

    always_ff @(posedge clock) begin
        if (!reset || !move_en) begin
            frame_cnt   <= '0;
            tap         <= '0;
            mv_p1_left  <= 1'b0;
            mv_p1_right <= 1'b0;
            mv_p2_left  <= 1'b0;
            mv_p2_right <= 1'b0;
        end else begin
            tap         <= (tap & ~(fire ? want : 4'b0000)) | tap_set;
            mv_p1_left  <= fire && strobe[0];
            mv_p1_right <= fire && strobe[1];
            mv_p2_left  <= fire && strobe[2];
            mv_p2_right <= fire && strobe[3];
            if (frame_tick) begin
                frame_cnt <= fire ? '0 : frame_cnt + CW'(1);
            end
        end
    end

endmodule
